avalon_multi_timer: RTL and testbench
=====================================

Name: avalon_multi_timer

Overview:
- Parametrised N-channel Avalon-MM interval timer. It is the successor to the single-channel 16-bit-bus SoC timer.
- Each channel has an independent down-counter of configurable width, one-shot or continuous mode, snapshot capture and its own interrupt.
- Per-channel IRQs and an OR-combined IRQ feed the Nios II interrupt controller.
- The block sits on the system interconnect as a single slave.

Parameters:
- NUM_CH, 4, number of independent timer channels (1..16)
- CNT_W, 32, counter/period width in bits (1..32); register bits above CNT_W read 0
- DATA_W, 32, Avalon data width (fixed 32; CNT_W <= DATA_W)
- DEFAULT_PERIOD, 49999, reset value of every period register and counter (truncated to CNT_W)
- ADDR_W, $clog2(NUM_CH)+2, derived; not overridden

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- address  in  ADDR_W  word address: [ADDR_W-1:2] channel, [1:0] register
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  DATA_W  write data
- readdata  out  DATA_W  registered read data
- irq  out  NUM_CH  per-channel interrupt
- irq_any  out  1  OR of irq

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. Everything samples on the rising edge of clk.
- Register map per channel:
  - 0 STATUS: bit0 TO, bit1 RUN. Writing 1 to bit0 clears TO (W1C); other bits ignored.
  - 1 CONTROL: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP. Bits [1:0] are stored; START and STOP are self-clearing strobes and read 0.
  - 2 PERIOD: CNT_W bits.
  - 3 SNAP: any write captures the live counter; a read returns the captured value.
- Reset: all counters and periods = DEFAULT_PERIOD; RUN=0, TO=0, CONTROL=0; readdata=0; irq=0; irq_any=0.
- Read latency: exactly 1 cycle. readdata is registered every cycle from the mux on address, independent of chipselect.
- Out-of-range channel (index >= NUM_CH): reads 0; writes ignored.
- PERIOD write: sets force_reload for 1 cycle. On the next cycle the counter loads PERIOD and RUN clears.
- Running channel, each cycle:
  - counter != 0: counter decrements by 1.
  - counter == 0: counter reloads PERIOD.
  - If CONT=0, RUN clears in the same cycle the counter is 0.
- Timeout event: rising edge of (counter == 0), using a 1-cycle delayed copy. The event sets TO.
- irq[i] = TO & ITO (combinational from registers). irq_any = |irq.
- Simultaneous events:
  - START and STOP in the same write: START wins.
  - TO clear and timeout event in the same cycle: set wins, so no event is lost.
  - START in the same cycle as force_reload: START wins, so RUN=1.
- PERIOD = 0 in continuous mode: counter stays 0; exactly one timeout event until the counter leaves 0.
- Reset asserted mid-count: all state returns to reset values on that edge. No IRQ is generated.
- Channels are fully independent. A write only affects the addressed channel.

Decomposition:
- Shared package avalon_timer_pkg:
  - register offsets: REG_STATUS=0, REG_CONTROL=1, REG_PERIOD=2, REG_SNAP=3
  - CONTROL bit indices: ITO=0, CONT=1, START=2, STOP=3
  - STATUS bit indices: TO=0, RUN=1
- One sub-module, timer_channel: counter, RUN/TO, control, period and snapshot for one channel.
  - Inputs: decoded per-register write strobes and writedata.
  - Outputs: status, control, period and snap words, plus irq.
- Top level: address decode, generate loop of NUM_CH channels, registered read mux, irq_any.

Test Plan:
- Reset: NUM_CH=2, CNT_W=16. After reset, read ch0 PERIOD -> 0x0000C34F one cycle later. STATUS -> 0. irq=2'b00.
- Continuous periodic IRQ: ch0 PERIOD=4, then CONTROL=0x7 (ITO|CONT|START). Counter sequence 4,3,2,1,0,4...; TO sets and irq[0] asserts. Write STATUS=1 to clear; the next timeout follows exactly 5 cycles after the previous one. irq[1] stays 0.
- One-shot: ch1 PERIOD=3, CONTROL=0x5 (ITO|START). After 3 decrements the counter is 0, RUN=0, irq[1]=1, irq_any=1. The counter holds 3 thereafter and no further events occur.
- Snapshot + stop: ch0 PERIOD=1000, start continuous; after 10 cycles write SNAP. Read SNAP -> value in 990..992, stable on re-read. Write CONTROL STOP: RUN reads 0 and the counter is frozen.
- Collisions:
  - W1C to STATUS in the exact cycle of a timeout event: TO remains 1.
  - CONTROL write with START|STOP: RUN=1.
  - PERIOD write while running: RUN=0 next cycle and counter == new PERIOD.
- Mid-operation reset and out-of-range access:
  - Assert reset during a count: all registers return to defaults; irq=0.
  - NUM_CH=3, write then read channel 3: readdata=0; no channel state changes.

Source files
------------

// File: rtl/avalon_timer_pkg.sv
// Shared register offsets and bit positions for the multi-channel Avalon timer.
package avalon_timer_pkg;

  typedef enum logic [1:0] {
    REG_STATUS  = 2'd0,
    REG_CONTROL = 2'd1,
    REG_PERIOD  = 2'd2,
    REG_SNAP    = 2'd3
  } reg_e;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: down-counter, RUN/TO flags, control, period and snapshot.
module timer_channel
  import avalon_timer_pkg::*;
#(
  parameter int CNT_W          = 32,
  parameter int DEFAULT_PERIOD = 49999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_status_i,
  input  logic             wr_control_i,
  input  logic             wr_period_i,
  input  logic             wr_snap_i,
  input  logic [3:0]       ctrl_dat_i,
  input  logic [CNT_W-1:0] period_dat_i,
  output logic             to_o,
  output logic             run_o,
  output logic             ito_o,
  output logic             cont_o,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] snap_o,
  output logic             irq_o
);

  localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(DEFAULT_PERIOD);

  logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d, snap_q, snap_d;
  logic             run_q, run_d, to_q, to_d, ito_q, ito_d, cont_q, cont_d;
  logic             reload_q, zero_dly_q;
  logic             is_zero, tmo, start, stop;

  assign is_zero = (cnt_q == '0);
  assign tmo     = is_zero & ~zero_dly_q;
  assign start   = wr_control_i & ctrl_dat_i[CTRL_START];
  assign stop    = wr_control_i & ctrl_dat_i[CTRL_STOP];

  always_comb begin
    cnt_d    = cnt_q;
    run_d    = run_q;
    to_d     = to_q;
    ito_d    = ito_q;
    cont_d   = cont_q;
    period_d = period_q;
    snap_d   = snap_q;
    if (reload_q)
      cnt_d = period_q;
    else if (run_q)
      cnt_d = is_zero ? period_q : cnt_q - CNT_W'(1);
    // START outranks every reason to stop, including a pending reload
    if (start)
      run_d = 1'b1;
    else if (stop || reload_q || (run_q && is_zero && !cont_q))
      run_d = 1'b0;
    if (tmo)
      to_d = 1'b1;
    else if (wr_status_i && ctrl_dat_i[STAT_TO])
      to_d = 1'b0;
    if (wr_control_i) begin
      ito_d  = ctrl_dat_i[CTRL_ITO];
      cont_d = ctrl_dat_i[CTRL_CONT];
    end
    if (wr_period_i)
      period_d = period_dat_i;
    if (wr_snap_i)
      snap_d = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= RST_VAL;
      period_q   <= RST_VAL;
      snap_q     <= '0;
      run_q      <= 1'b0;
      to_q       <= 1'b0;
      ito_q      <= 1'b0;
      cont_q     <= 1'b0;
      reload_q   <= 1'b0;
      // Treat the counter as already at zero so reset never fakes a timeout edge
      zero_dly_q <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      snap_q     <= snap_d;
      run_q      <= run_d;
      to_q       <= to_d;
      ito_q      <= ito_d;
      cont_q     <= cont_d;
      reload_q   <= wr_period_i;
      zero_dly_q <= is_zero;
    end
  end

  assign to_o     = to_q;
  assign run_o    = run_q;
  assign ito_o    = ito_q;
  assign cont_o   = cont_q;
  assign period_o = period_q;
  assign snap_o   = snap_q;
  assign irq_o    = to_q & ito_q;

endmodule

// File: rtl/avalon_multi_timer.sv
// N-channel Avalon-MM interval timer: address decode, channel array, registered read mux.
module avalon_multi_timer
  import avalon_timer_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 32,
  parameter int DATA_W         = 32,
  parameter int DEFAULT_PERIOD = 49999,
  parameter int ADDR_W         = $clog2(NUM_CH) + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic [NUM_CH-1:0] irq,
  output logic              irq_any
);

  logic [ADDR_W-1:0] ch_sel;
  reg_e              reg_sel;
  logic              wr_en;
  logic              unused_wdata;
  logic [NUM_CH-1:0] to_w, run_w, ito_w, cont_w;
  logic [CNT_W-1:0]  period_w [NUM_CH];
  logic [CNT_W-1:0]  snap_w   [NUM_CH];
  logic [DATA_W-1:0] rdata_d, rdata_q;

  assign ch_sel       = address >> 2;
  assign reg_sel      = reg_e'(address[1:0]);
  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic hit;
    assign hit = wr_en && (ch_sel == ADDR_W'(i));

    timer_channel #(
      .CNT_W          (CNT_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .wr_status_i  (hit && (reg_sel == REG_STATUS)),
      .wr_control_i (hit && (reg_sel == REG_CONTROL)),
      .wr_period_i  (hit && (reg_sel == REG_PERIOD)),
      .wr_snap_i    (hit && (reg_sel == REG_SNAP)),
      .ctrl_dat_i   (writedata[3:0]),
      .period_dat_i (writedata[CNT_W-1:0]),
      .to_o         (to_w[i]),
      .run_o        (run_w[i]),
      .ito_o        (ito_w[i]),
      .cont_o       (cont_w[i]),
      .period_o     (period_w[i]),
      .snap_o       (snap_w[i]),
      .irq_o        (irq[i])
    );
  end

  // Channel indices past NUM_CH match no entry and read back as zero
  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == ADDR_W'(i)) begin
        case (reg_sel)
          REG_STATUS: begin
            rdata_d[STAT_TO]  = to_w[i];
            rdata_d[STAT_RUN] = run_w[i];
          end
          REG_CONTROL: begin
            rdata_d[CTRL_ITO]  = ito_w[i];
            rdata_d[CTRL_CONT] = cont_w[i];
          end
          REG_PERIOD: rdata_d = DATA_W'(period_w[i]);
          default:    rdata_d = DATA_W'(snap_w[i]);
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign readdata = rdata_q;
  assign irq_any  = |irq;

endmodule

// File: tb/tb_avalon_multi_timer.sv
// Directed scenarios plus randomized register traffic against a cycle model of the timer rules.
module tb_avalon_multi_timer;

  localparam int NCH = 3;
  localparam int CW  = 16;
  localparam int AW  = 4;
  localparam int DEF = 49999;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [NCH-1:0] irq;
  logic          irq_any;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  avalon_multi_timer #(
    .NUM_CH(NCH), .CNT_W(CW), .DATA_W(32), .DEFAULT_PERIOD(DEF)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq(irq), .irq_any(irq_any)
  );

  // Reference model: per-channel state stepped once per clock from the register rules
  int m_cnt[NCH], m_per[NCH], m_snap[NCH], m_ev[NCH];
  bit m_run[NCH], m_to[NCH], m_ito[NCH], m_cont[NCH], m_fr[NCH], m_zp[NCH];
  int m_rd;

  always @(posedge clk) begin
    int ch, rg, nc;
    bit wr, hit, zero, st, sp;
    cyc++;
    ch = int'(address) >> 2;
    rg = int'(address) & 3;
    wr = chipselect && !write_n;
    if (reset) begin
      m_rd = 0;
      for (int i = 0; i < NCH; i++) begin
        m_cnt[i] = DEF % (1 << CW); m_per[i] = DEF % (1 << CW); m_snap[i] = 0;
        m_run[i] = 0; m_to[i] = 0; m_ito[i] = 0; m_cont[i] = 0; m_fr[i] = 0; m_zp[i] = 1;
      end
    end else begin
      m_rd = 0;
      if (ch < NCH) begin
        case (rg)
          0: m_rd = (m_run[ch] ? 2 : 0) + (m_to[ch] ? 1 : 0);
          1: m_rd = (m_cont[ch] ? 2 : 0) + (m_ito[ch] ? 1 : 0);
          2: m_rd = m_per[ch];
          default: m_rd = m_snap[ch];
        endcase
      end
      for (int i = 0; i < NCH; i++) begin
        hit  = wr && (ch == i);
        zero = (m_cnt[i] == 0);
        st   = hit && rg == 1 && writedata[2];
        sp   = hit && rg == 1 && writedata[3];
        if (zero && !m_zp[i]) begin m_to[i] = 1; m_ev[i]++; end
        else if (hit && rg == 0 && writedata[0]) m_to[i] = 0;
        m_zp[i] = zero;
        if (hit && rg == 3) m_snap[i] = m_cnt[i];
        if (m_fr[i])       nc = m_per[i];
        else if (m_run[i]) nc = zero ? m_per[i] : m_cnt[i] - 1;
        else               nc = m_cnt[i];
        if (st) m_run[i] = 1;
        else if (sp || m_fr[i] || (m_run[i] && zero && !m_cont[i])) m_run[i] = 0;
        m_cnt[i] = nc;
        m_fr[i]  = hit && rg == 2;
        if (hit && rg == 2) m_per[i] = int'(writedata[CW-1:0]);
        if (hit && rg == 1) begin m_ito[i] = writedata[0]; m_cont[i] = writedata[1]; end
      end
    end
  end

  task automatic bus_write(input int ch, input int rg, input logic [31:0] d);
    @(negedge clk);
    address = AW'(ch * 4 + rg); chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input int ch, input int rg, output logic [31:0] d);
    @(negedge clk);
    address = AW'(ch * 4 + rg); chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    d = readdata; chipselect = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_tests++; if (irq !== 3'b000 || irq_any !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b/%b expected 000/0", irq, irq_any); end
    n_tests++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL reset_readdata: got %h expected 0", readdata); end
    bus_read(0, 2, d);
    n_tests++; if (d !== 32'h0000C34F) begin n_fail++; $display("FAIL reset_period: got %h expected 0000c34f", d); end
    bus_read(0, 0, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h expected 0", d); end
    bus_read(2, 1, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_control: got %h expected 0", d); end
  endtask

  task automatic test_continuous();
    logic [31:0] d;
    int lat, t1, t2;
    bus_write(0, 2, 4);
    bus_write(0, 1, 32'h7);
    lat = -1;
    for (int k = 0; k < 20 && lat < 0; k++) begin @(negedge clk); if (irq[0]) begin lat = k + 1; t1 = cyc; end end
    n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL cont_first_latency: got %0d expected 5", lat); end
    bus_read(0, 0, d);
    n_tests++; if (d[0] !== 1'b1) begin n_fail++; $display("FAIL cont_to_set: got %h expected bit0=1", d); end
    bus_write(0, 0, 32'h1);
    n_tests++; if (irq[0] !== 1'b0) begin n_fail++; $display("FAIL cont_w1c: got %b expected 0", irq[0]); end
    t2 = -1;
    for (int k = 0; k < 20 && t2 < 0; k++) begin @(negedge clk); if (irq[0]) t2 = cyc; end
    n_tests++; if (t2 - t1 !== 5) begin n_fail++; $display("FAIL cont_interval: got %0d expected 5", t2 - t1); end
    n_tests++; if (irq[2:1] !== 2'b00) begin n_fail++; $display("FAIL cont_other_irq: got %b expected 00", irq[2:1]); end
    bus_write(0, 1, 32'h8);
    bus_write(0, 0, 32'h1);
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    int seen;
    bus_write(1, 2, 3);
    bus_write(1, 1, 32'h5);
    seen = -1;
    for (int k = 0; k < 10 && seen < 0; k++) begin @(negedge clk); if (irq[1]) seen = k + 1; end
    n_tests++; if (seen !== 4) begin n_fail++; $display("FAIL oneshot_latency: got %0d expected 4", seen); end
    n_tests++; if (irq_any !== 1'b1) begin n_fail++; $display("FAIL oneshot_irq_any: got %b expected 1", irq_any); end
    bus_read(1, 0, d);
    n_tests++; if (d !== 32'h1) begin n_fail++; $display("FAIL oneshot_status: got %h expected 1", d); end
    bus_write(1, 0, 32'h1);
    repeat (30) @(negedge clk);
    n_tests++; if (irq[1] !== 1'b0) begin n_fail++; $display("FAIL oneshot_no_rearm: got %b expected 0", irq[1]); end
    bus_write(1, 3, 0);
    bus_read(1, 3, d);
    n_tests++; if (d !== 32'd3) begin n_fail++; $display("FAIL oneshot_hold: got %0d expected 3", d); end
  endtask

  task automatic test_snapshot_stop();
    logic [31:0] d, v1, v2;
    bus_write(0, 2, 1000);
    bus_write(0, 1, 32'h6);
    repeat (8) @(negedge clk);
    bus_write(0, 3, 0);
    bus_read(0, 3, d);
    n_tests++; if (d < 990 || d > 992) begin n_fail++; $display("FAIL snap_range: got %0d expected 990..992", d); end
    bus_read(0, 3, d);
    n_tests++; if (d !== 32'(m_snap[0]) || d < 990 || d > 992) begin n_fail++; $display("FAIL snap_reread: got %0d expected %0d", d, m_snap[0]); end
    bus_write(0, 1, 32'hA);
    bus_read(0, 0, d);
    n_tests++; if (d[1] !== 1'b0) begin n_fail++; $display("FAIL stop_run: got %h expected bit1=0", d); end
    bus_write(0, 3, 0);
    bus_read(0, 3, v1);
    n_tests++; if (v1 !== 32'(m_snap[0]) || v1 >= 990) begin n_fail++; $display("FAIL stop_snap1: got %0d expected %0d", v1, m_snap[0]); end
    repeat (10) @(negedge clk);
    bus_write(0, 3, 0);
    bus_read(0, 3, v2);
    n_tests++; if (v2 !== 32'(m_snap[0])) begin n_fail++; $display("FAIL stop_frozen: got %0d expected %0d", v2, m_snap[0]); end
  endtask

  task automatic test_collisions();
    logic [31:0] d;
    bus_write(2, 2, 5);
    bus_write(2, 1, 32'h7);
    repeat (4) @(negedge clk);
    bus_write(2, 0, 32'h1);
    n_tests++; if (irq[2] !== 1'b1) begin n_fail++; $display("FAIL w1c_vs_timeout: got %b expected 1", irq[2]); end
    bus_write(2, 2, 9);
    bus_read(2, 0, d);
    n_tests++; if (d[1] !== 1'b0) begin n_fail++; $display("FAIL period_write_run: got %h expected bit1=0", d); end
    bus_write(2, 3, 0);
    bus_read(2, 3, d);
    n_tests++; if (d !== 32'd9) begin n_fail++; $display("FAIL period_write_reload: got %0d expected 9", d); end
    bus_write(1, 1, 32'hC);
    bus_read(1, 0, d);
    n_tests++; if (d[1] !== 1'b1) begin n_fail++; $display("FAIL start_vs_stop: got %h expected bit1=1", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bus_write(0, 2, 3);
    bus_write(0, 1, 32'h7);
    repeat (20) @(negedge clk);
    n_tests++; if (irq[0] !== 1'b1) begin n_fail++; $display("FAIL midreset_pre_irq: got %b expected 1", irq[0]); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_tests++; if (irq !== 3'b000 || irq_any !== 1'b0 || readdata !== 32'h0) begin n_fail++; $display("FAIL midreset_out: got %b/%b/%h expected 000/0/0", irq, irq_any, readdata); end
    bus_read(0, 2, d);
    n_tests++; if (d !== 32'h0000C34F) begin n_fail++; $display("FAIL midreset_period: got %h expected 0000c34f", d); end
    bus_read(0, 1, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL midreset_control: got %h expected 0", d); end
    repeat (10) @(negedge clk);
    n_tests++; if (irq !== 3'b000) begin n_fail++; $display("FAIL midreset_post_irq: got %b expected 000", irq); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d;
    bus_write(3, 2, 7);
    bus_write(3, 1, 32'h7);
    bus_write(3, 3, 0);
    for (int r = 0; r < 4; r++) begin
      bus_read(3, r, d);
      n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL oor_read reg%0d: got %h expected 0", r, d); end
    end
    for (int c = 0; c < NCH; c++) begin
      bus_read(c, 2, d);
      n_tests++; if (d !== 32'h0000C34F) begin n_fail++; $display("FAIL oor_side_period ch%0d: got %h expected 0000c34f", c, d); end
      bus_read(c, 1, d);
      n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL oor_side_control ch%0d: got %h expected 0", c, d); end
    end
  endtask

  task automatic test_random();
    logic [NCH-1:0] e;
    int r;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++) e[i] = m_to[i] & m_ito[i];
      n_tests++; if (readdata !== 32'(m_rd)) begin n_fail++; $display("FAIL rand_readdata cyc%0d: got %h expected %h", cyc, readdata, m_rd); end
      n_tests++; if (irq !== e || irq_any !== (|e)) begin n_fail++; $display("FAIL rand_irq cyc%0d: got %b/%b expected %b", cyc, irq, irq_any, e); end
      r = $urandom_range(0, 9);
      address    = AW'($urandom_range(0, 15));
      chipselect = (r < 7);
      write_n    = !(r < 3);
      case (address[1:0])
        2'd2:    writedata = $urandom_range(0, 12);
        2'd1:    writedata = $urandom_range(0, 15);
        default: writedata = $urandom;
      endcase
    end
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    test_reset();
    test_continuous();
    test_oneshot();
    test_snapshot_stop();
    test_collisions();
    test_reset_mid();
    test_out_of_range();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
